id_ex_stage: RTL and testbench

//  ID/EX pipeline register and EX operand front-end of the RV32I core. It captures

---
 rtl/riscv_pkg.sv | 17 +
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 tb/tb_id_ex_stage.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core types: ALU operation encoding used by decode, EX and the ALU.
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ops_t;

endpackage

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus EX operand front-end: MEM/WB forwarding, operand
// selection for the ALU and load-use bubble insertion.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [4:0]      id_rd_addr,
    input  logic [XLEN-1:0] id_imm,
    input  alu_ops_t        id_alu_ctrl,
    input  logic            id_use_imm,
    input  logic            id_use_pc,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,

    input  logic            stall,
    input  logic            flush,

    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd_addr,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_result,

    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output alu_ops_t        alu_ctrl,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [XLEN-1:0] ex_store_data,
    output logic            load_use_hazard
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] imm;
        alu_ops_t        alu_ctrl;
        logic            use_imm;
        logic            use_pc;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } ex_regs_t;

    ex_regs_t ex_q, ex_d;
    ex_regs_t bubble;
    ex_regs_t captured;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Hazard looks only at the EX load and the ID sources; upstream stalls IF/ID on it.
    always_comb begin
        load_use_hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != 5'd0) && id_valid &&
                          ((ex_q.rd_addr == id_rs1_addr) || (ex_q.rd_addr == id_rs2_addr));
    end

    // A bubble is the reset image: every field zero, which also zeroes the operands.
    always_comb begin
        bubble          = '0;
        bubble.alu_ctrl = ALU_ADD;
    end

    always_comb begin
        captured.valid     = id_valid;
        captured.pc        = id_pc;
        captured.rs1_addr  = id_rs1_addr;
        captured.rs2_addr  = id_rs2_addr;
        captured.rs1_data  = id_rs1_data;
        captured.rs2_data  = id_rs2_data;
        captured.rd_addr   = id_rd_addr;
        captured.imm       = id_imm;
        captured.alu_ctrl  = id_alu_ctrl;
        captured.use_imm   = id_use_imm;
        captured.use_pc    = id_use_pc;
        captured.reg_write = id_reg_write;
        captured.mem_read  = id_mem_read;
        captured.mem_write = id_mem_write;
    end

    // flush > stall > load-use bubble > load
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = bubble;
        end else if (stall) begin
            ex_d = ex_q;
        end else if (load_use_hazard) begin
            ex_d = bubble;
        end else begin
            ex_d = captured;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= bubble;
        end else begin
            ex_q <= ex_d;
        end
    end

    // MEM is younger than WB, so it wins on a double hit; x0 is never forwarded.
    always_comb begin
        fwd_rs1 = ex_q.rs1_data;
        fwd_rs2 = ex_q.rs2_data;
        if (FWD_EN) begin
            if (mem_reg_write && (mem_rd_addr != 5'd0) && (mem_rd_addr == ex_q.rs1_addr)) begin
                fwd_rs1 = mem_result;
            end else if (wb_reg_write && (wb_rd_addr != 5'd0) &&
                         (wb_rd_addr == ex_q.rs1_addr)) begin
                fwd_rs1 = wb_result;
            end
            if (mem_reg_write && (mem_rd_addr != 5'd0) && (mem_rd_addr == ex_q.rs2_addr)) begin
                fwd_rs2 = mem_result;
            end else if (wb_reg_write && (wb_rd_addr != 5'd0) &&
                         (wb_rd_addr == ex_q.rs2_addr)) begin
                fwd_rs2 = wb_result;
            end
        end
    end

    always_comb begin
        alu_a         = ex_q.use_pc  ? ex_q.pc  : fwd_rs1;
        alu_b         = ex_q.use_imm ? ex_q.imm : fwd_rs2;
        ex_store_data = fwd_rs2;
        alu_ctrl      = ex_q.alu_ctrl;
        ex_valid      = ex_q.valid;
        ex_pc         = ex_q.pc;
        ex_rd_addr    = ex_q.rd_addr;
        ex_reg_write  = ex_q.valid && ex_q.reg_write;
        ex_mem_read   = ex_q.valid && ex_q.mem_read;
        ex_mem_write  = ex_q.valid && ex_q.mem_write;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed forwarding table, hazard/stall/flush
// sequences and randomized traffic against a record-level pipeline model.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    alu_ops_t    id_alu_ctrl;
    logic        id_use_imm, id_use_pc, id_reg_write, id_mem_read, id_mem_write;
    logic        stall, flush;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic [31:0] mem_result, wb_result;
    logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
    alu_ops_t    alu_ctrl;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
    logic [4:0]  ex_rd_addr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rd_addr(id_rd_addr), .id_imm(id_imm), .id_alu_ctrl(id_alu_ctrl),
        .id_use_imm(id_use_imm), .id_use_pc(id_use_pc), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .stall(stall), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
    );

    // Model: the instruction record that currently sits in EX.
    typedef struct {
        bit          valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        alu_ops_t    ctrl;
        bit          use_imm, use_pc, rw, mr, mw;
    } instr_t;

    instr_t model;

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [31:0] rs1d, rs2d, pc, imm;
        alu_ops_t    ctrl;
        bit          use_pc, use_imm;
        bit          mem_we;
        logic [4:0]  mem_rd;
        logic [31:0] mem_res;
        bit          wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_res;
        logic [31:0] exp_a, exp_b, exp_st;
    } fwd_vec_t;

    fwd_vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic instr_t empty_instr();
        instr_t e;
        e.valid = 0; e.pc = 0; e.rs1d = 0; e.rs2d = 0; e.imm = 0;
        e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.ctrl = ALU_ADD;
        e.use_imm = 0; e.use_pc = 0; e.rw = 0; e.mr = 0; e.mw = 0;
        return e;
    endfunction

    // Value the EX instruction sees for a source register, given the MEM/WB writers.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] regval);
        if (r == 0) return regval;
        if (mem_reg_write && mem_rd_addr == r) return mem_result;
        if (wb_reg_write && wb_rd_addr == r) return wb_result;
        return regval;
    endfunction

    function automatic bit exp_hazard();
        return model.valid && model.mr && model.rd != 0 && id_valid &&
               (model.rd == id_rs1_addr || model.rd == id_rs2_addr);
    endfunction

    function automatic instr_t model_next();
        instr_t n;
        n = model;
        if (flush || (!stall && exp_hazard())) n = empty_instr();
        else if (!stall) begin
            n.valid = id_valid; n.pc = id_pc; n.rs1 = id_rs1_addr; n.rs2 = id_rs2_addr;
            n.rs1d = id_rs1_data; n.rs2d = id_rs2_data; n.rd = id_rd_addr; n.imm = id_imm;
            n.ctrl = id_alu_ctrl; n.use_imm = id_use_imm; n.use_pc = id_use_pc;
            n.rw = id_reg_write; n.mr = id_mem_read; n.mw = id_mem_write;
        end
        return n;
    endfunction

    task automatic tick();
        instr_t nx;
        nx = model_next();
        @(posedge clk);
        model = nx;
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] s2;
        chk({tag, " ex_valid"}, 32'(ex_valid), 32'(model.valid));
        chk({tag, " ex_reg_write"}, 32'(ex_reg_write), 32'(model.valid && model.rw));
        chk({tag, " ex_mem_read"}, 32'(ex_mem_read), 32'(model.valid && model.mr));
        chk({tag, " ex_mem_write"}, 32'(ex_mem_write), 32'(model.valid && model.mw));
        chk({tag, " hazard"}, 32'(load_use_hazard), 32'(exp_hazard()));
        if (model.valid) begin
            s2 = operand(model.rs2, model.rs2d);
            chk({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'(model.ctrl));
            chk({tag, " ex_pc"}, ex_pc, model.pc);
            chk({tag, " ex_rd"}, 32'(ex_rd_addr), 32'(model.rd));
            chk({tag, " alu_a"}, alu_a, model.use_pc ? model.pc : operand(model.rs1, model.rs1d));
            chk({tag, " alu_b"}, alu_b, model.use_imm ? model.imm : s2);
            chk({tag, " store"}, ex_store_data, s2);
        end
    endtask

    task automatic set_id(input bit v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [4:0] rd, input logic [31:0] imm, input alu_ops_t c,
                          input bit ui, input bit up, input bit rw, input bit mr, input bit mw);
        id_valid = v; id_pc = pc; id_rs1_addr = rs1; id_rs2_addr = rs2;
        id_rs1_data = d1; id_rs2_data = d2; id_rd_addr = rd; id_imm = imm;
        id_alu_ctrl = c; id_use_imm = ui; id_use_pc = up;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic quiet_fwd();
        mem_reg_write = 0; mem_rd_addr = 0; mem_result = 0;
        wb_reg_write = 0; wb_rd_addr = 0; wb_result = 0;
    endtask

    initial begin
        vecs[0] = '{5, 1, 32'hAAAA, 32'h3, 32'h40, 0, ALU_SUB, 0, 0,
                    1, 5, 32'h10, 0, 0, 0, 32'h10, 32'h3, 32'h3};
        vecs[1] = '{5, 5, 32'h99, 32'h99, 32'h44, 0, ALU_ADD, 0, 0,
                    1, 5, 32'h11, 1, 5, 32'h22, 32'h11, 32'h11, 32'h11};
        vecs[2] = '{0, 0, 32'h7, 32'h8, 32'h48, 0, ALU_OR, 0, 0,
                    1, 0, 32'h55, 1, 0, 32'h66, 32'h7, 32'h8, 32'h8};
        vecs[3] = '{3, 4, 32'h33, 32'h34, 32'h4C, 0, ALU_XOR, 0, 0,
                    1, 1, 32'hF1, 1, 4, 32'h44, 32'h33, 32'h44, 32'h44};
        vecs[4] = '{5, 5, 32'h1, 32'h2, 32'h100, 32'h8, ALU_ADD, 1, 1,
                    1, 5, 32'hABC, 0, 0, 0, 32'h100, 32'h8, 32'hABC};
        vecs[5] = '{6, 7, 32'h60, 32'h70, 32'h54, 0, ALU_AND, 0, 0,
                    0, 6, 32'hBAD, 1, 6, 32'h600, 32'h600, 32'h70, 32'h70};

        rst_n = 0; stall = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0);
        quiet_fwd();
        model = empty_instr();
        #2;
        chk("reset ex_valid", 32'(ex_valid), 0);
        chk("reset alu_a", alu_a, 0);
        chk("reset alu_b", alu_b, 0);
        chk("reset alu_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
        chk("reset hazard", 32'(load_use_hazard), 0);
        #10 rst_n = 1;
        @(posedge clk); #1;

        // Forwarding table: load instruction, then present MEM/WB writers.
        foreach (vecs[i]) begin
            quiet_fwd();
            set_id(1, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].rs1d, vecs[i].rs2d,
                   5'd10, vecs[i].imm, vecs[i].ctrl, vecs[i].use_imm, vecs[i].use_pc,
                   1, 0, 0);
            tick();
            mem_reg_write = vecs[i].mem_we; mem_rd_addr = vecs[i].mem_rd;
            mem_result = vecs[i].mem_res;
            wb_reg_write = vecs[i].wb_we; wb_rd_addr = vecs[i].wb_rd;
            wb_result = vecs[i].wb_res;
            #1;
            chk($sformatf("vec%0d alu_a", i), alu_a, vecs[i].exp_a);
            chk($sformatf("vec%0d alu_b", i), alu_b, vecs[i].exp_b);
            chk($sformatf("vec%0d store", i), ex_store_data, vecs[i].exp_st);
            chk($sformatf("vec%0d ctrl", i), 32'(alu_ctrl), 32'(vecs[i].ctrl));
            chk($sformatf("vec%0d valid", i), 32'(ex_valid), 1);
        end

        // Load-use: lw x7 followed by add x8,x7,x7.
        quiet_fwd();
        set_id(1, 32'h80, 2, 0, 32'h1000, 0, 7, 0, ALU_ADD, 1, 0, 1, 1, 0);
        tick();
        set_id(1, 32'h84, 7, 7, 32'hBAD0, 32'hBAD1, 8, 0, ALU_ADD, 0, 0, 1, 0, 0);
        #1;
        chk("lu hazard on", 32'(load_use_hazard), 1);
        chk("lu ex_mem_read", 32'(ex_mem_read), 1);
        tick();
        chk("lu bubble valid", 32'(ex_valid), 0);
        chk("lu bubble reg_write", 32'(ex_reg_write), 0);
        chk("lu hazard off", 32'(load_use_hazard), 0);
        tick();
        wb_reg_write = 1; wb_rd_addr = 7; wb_result = 32'h1234_5678;
        #1;
        chk("lu add valid", 32'(ex_valid), 1);
        chk("lu add alu_a", alu_a, 32'h1234_5678);
        chk("lu add alu_b", alu_b, 32'h1234_5678);

        // flush with stall wins; then stall holds EX for three cycles.
        quiet_fwd();
        set_id(1, 32'h200, 0, 0, 0, 0, 3, 32'h7, ALU_SLT, 1, 1, 1, 0, 0);
        tick();
        flush = 1; stall = 1;
        tick();
        flush = 0; stall = 0;
        chk("flush+stall valid", 32'(ex_valid), 0);
        chk("flush+stall reg_write", 32'(ex_reg_write), 0);
        chk("flush+stall ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
        tick();
        stall = 1;
        set_id(1, 32'h300, 1, 2, 5, 6, 9, 32'h99, ALU_SRA, 0, 0, 0, 0, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d valid", c), 32'(ex_valid), 1);
            chk($sformatf("stall%0d pc", c), ex_pc, 32'h200);
            chk($sformatf("stall%0d alu_a", c), alu_a, 32'h200);
            chk($sformatf("stall%0d alu_b", c), alu_b, 32'h7);
            chk($sformatf("stall%0d rd", c), 32'(ex_rd_addr), 3);
            chk($sformatf("stall%0d ctrl", c), 32'(alu_ctrl), 32'(ALU_SLT));
            chk($sformatf("stall%0d mem_write", c), 32'(ex_mem_write), 0);
        end
        stall = 0;

        // sw x9,4(x2) with x9 produced by the MEM-stage instruction.
        set_id(1, 32'h400, 2, 9, 32'h2000, 32'h1111, 0, 32'h4, ALU_ADD, 1, 0, 0, 0, 1);
        tick();
        mem_reg_write = 1; mem_rd_addr = 9; mem_result = 32'hDEAD;
        #1;
        chk("sw alu_b", alu_b, 32'h4);
        chk("sw store", ex_store_data, 32'hDEAD);
        chk("sw alu_a", alu_a, 32'h2000);
        chk("sw mem_write", 32'(ex_mem_write), 1);

        // Randomized traffic on a small register window to hit forwarding and hazards.
        for (int n = 0; n < 600; n++) begin
            set_id($urandom_range(0, 7) != 0, $urandom, 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 3)),
                   $urandom, alu_ops_t'($urandom_range(0, 9)), 1'($urandom),
                   1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
                   $urandom_range(0, 3) == 0);
            stall = $urandom_range(0, 7) == 0;
            flush = $urandom_range(0, 9) == 0;
            mem_reg_write = 1'($urandom); mem_rd_addr = 5'($urandom_range(0, 3));
            mem_result = $urandom;
            wb_reg_write = 1'($urandom); wb_rd_addr = 5'($urandom_range(0, 3));
            wb_result = $urandom;
            #1;
            check_model("rnd");
            tick();
        end

        // Asynchronous reset in the middle of traffic.
        stall = 0; flush = 0;
        set_id(1, 32'h500, 1, 2, 32'h5, 32'h6, 4, 0, ALU_SUB, 0, 0, 1, 1, 0);
        tick();
        #3 rst_n = 0;
        #1;
        chk("midreset ex_valid", 32'(ex_valid), 0);
        chk("midreset alu_a", alu_a, 0);
        chk("midreset alu_b", alu_b, 0);
        chk("midreset ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
        chk("midreset mem_read", 32'(ex_mem_read), 0);
        #2 rst_n = 1;
        model = empty_instr();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
